tlp_tx_arbiter: RTL and testbench
=================================

# tlp_tx_arbiter

Packet-atomic round-robin arbiter that shares the single FPGA->Host TLP transmit pipe of the PCIe core wrapper between several requesters (e.g. completion generator, DMA write engine, interrupt/message generator). Sits between the application logic and the wrapper's `txData/txSOP/txEOP/txValid/txReady` inputs. Holds a grant from SOP to EOP so TLPs are never interleaved. Includes a 2-entry output skid buffer so `txReady_in` has no combinational path to any requester ready.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.

Ports:
- `pcieClk_in`  in  1  sole clock; all logic on rising edge.
- `reset_in`  in  1  synchronous, active-high reset.
- `reqData_in`  in  NUM_REQ x 64  per-requester TLP beat (`makestuff_tlp_xcvr_pkg::uint64` each).
- `reqSOP_in`  in  NUM_REQ  per-requester start-of-packet flag.
- `reqEOP_in`  in  NUM_REQ  per-requester end-of-packet flag.
- `reqValid_in`  in  NUM_REQ  per-requester beat valid.
- `reqReady_out`  out  NUM_REQ  per-requester beat accepted when valid&ready.
- `txData_out`  out  64  beat to PCIe core transmit pipe.
- `txSOP_out`  out  1  start-of-packet to core.
- `txEOP_out`  out  1  end-of-packet to core.
- `txValid_out`  out  1  beat valid to core.
- `txReady_in`  in  1  core accepts beat when valid&ready.
- `grant_out`  out  NUM_REQ  one-hot current grant, all-zero when idle.
- `protocolErr_out`  out  1  sticky: a valid non-SOP beat was presented by a non-granted requester.

## Operation
- States: IDLE, LOCKED(k). Round-robin pointer `last` (index of last granted requester).
- IDLE: eligible = `reqValid_in[i] & reqSOP_in[i]`. Choose first eligible index scanning `last+1, last+2, …` modulo NUM_REQ. If any eligible and skid buffer has room, grant asserts combinationally that cycle, `reqReady_out[k]`=1, first beat accepted; `last`<=k.
- Beat with SOP&EOP (single-beat TLP) accepted in IDLE: state stays IDLE, `last` still updates.
- Otherwise after first beat: state LOCKED(k). Only requester k gets ready; others held at 0 regardless of valid.
- LOCKED(k): leave to IDLE on the cycle after an accepted beat from k with EOP=1. One input-side idle cycle between multi-beat packets.
- SOP seen from k while LOCKED(k): beat forwarded unchanged, no state change (no internal correction).
- Non-granted requester with valid=1, SOP=0 while in IDLE: not eligible, not accepted, `protocolErr_out` sets and remains 1 until reset.
- Skid buffer: 2 entries of {data, SOP, EOP}, FIFO order. `reqReady_out[k]` = granted(k) & (count != 2); depends only on registered count. Head drives tx outputs; pop when `txValid_out & txReady_in`. Push and pop in same cycle: count unchanged.
- Data, SOP, EOP pass unmodified; no reordering within or across packets.

## Timing
- Reset values: `reqReady_out`=0, `txValid_out`=0, `txSOP_out`=0, `txEOP_out`=0, `txData_out`=0, `grant_out`=0, `protocolErr_out`=0, count=0, state IDLE, `last`=NUM_REQ-1 (requester 0 first priority).
- Latency: beat accepted from requester at cycle N appears on tx outputs at N+1 (when buffer was empty).
- Throughput: with `txReady_in` held 1, one beat/cycle within a packet; count stays ≤1.
- `txReady_in` low: buffer fills to 2, requester ready drops the following cycle; no beat lost or duplicated. tx outputs stable while `txValid_out`=1 and `txReady_in`=0.
- Reset mid-packet: next cycle all outputs at reset values, buffer flushed, partial packet discarded; downstream must tolerate truncation (core is also in reset on PERST).
- Requester dropping valid mid-packet: grant held, bubbles pass through, no timeout.

## Test plan
- Single requester: req0 sends 4-beat TLP 0x1000..0x1003, txReady=1 -> tx shows same 4 beats on cycles N+1..N+4, SOP on 0x1000, EOP on 0x1003, `grant_out`=01 for beats, then 00.
- Contention: req0 and req1 both present 3-beat TLPs after reset -> req0 packet fully, one idle cycle, then req1 packet; no interleave; next round with both pending starts with req0 again only after req1 (round-robin order 0,1,0,1).
- Backpressure: txReady toggles 1,0,0,1,… during 8-beat packet -> all 8 beats delivered in order once each; `reqReady_out` never 1 when count=2; outputs stable while stalled.
- Single-beat TLPs: req0 and req1 each stream SOP&EOP beats continuously -> alternating grants, one beat per cycle total, no protocolErr.
- Error: req1 presents valid, SOP=0 while IDLE -> beat not accepted, `protocolErr_out`=1 next cycle and stays 1 until `reset_in`.
- Reset mid-packet: reset after beat 2 of 5 -> next cycle txValid=0, grant=0, count=0; a fresh TLP from req1 afterward transmits correctly.

Source files
------------

// File: rtl/tlp_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tlp_tx_arbiter
// Brief   : Packet-atomic round-robin arbiter feeding the single FPGA->Host
//           TLP transmit pipe, with a 2-entry output skid buffer that breaks
//           the txReady_in -> reqReady_out combinational path.
// Revision: 1.0 - initial release
// ============================================================================
module tlp_tx_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                      pcieClk_in,
  input  logic                      reset_in,
  input  logic [NUM_REQ-1:0][63:0]  reqData_in,
  input  logic [NUM_REQ-1:0]        reqSOP_in,
  input  logic [NUM_REQ-1:0]        reqEOP_in,
  input  logic [NUM_REQ-1:0]        reqValid_in,
  output logic [NUM_REQ-1:0]        reqReady_out,
  output logic [63:0]               txData_out,
  output logic                      txSOP_out,
  output logic                      txEOP_out,
  output logic                      txValid_out,
  input  logic                      txReady_in,
  output logic [NUM_REQ-1:0]        grant_out,
  output logic                      protocolErr_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // GAP is the single dead cycle after a multi-beat packet ends.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [1:0][65:0]  mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   cur_idx;
  logic               sel_found;
  logic               full;
  logic               accept;
  logic               pop;
  logic               in_sop;
  logic               in_eop;
  logic [65:0]        head;

  assign eligible = reqValid_in & reqSOP_in;
  assign full     = (count_q == 2'd2);

  // Round-robin scan for the first SOP-valid requester after the last winner.
  always_comb begin : arb_scan
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_q) + off) % NUM_REQ);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // FSM outputs: grant is held for the owner while locked, dropped during reset.
  always_comb begin : fsm_out
    grant   = '0;
    cur_idx = owner_q;
    if (!reset_in) begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found && !full) begin
            grant[sel_idx] = 1'b1;
            cur_idx        = sel_idx;
          end
        end
        ST_LOCKED: grant[owner_q] = 1'b1;
        default: ;
      endcase
    end
  end

  assign reqReady_out = grant & {NUM_REQ{!full}};
  assign accept       = |(reqValid_in & reqReady_out);
  assign in_sop       = reqSOP_in[cur_idx];
  assign in_eop       = reqEOP_in[cur_idx];

  // FSM next state: lock on a multi-beat SOP, release after the owner's EOP.
  always_comb begin : fsm_next
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          last_d = sel_idx;
          if (!(in_sop && in_eop)) begin
            state_d = ST_LOCKED;
            owner_d = sel_idx;
          end
        end
      end
      ST_LOCKED: if (accept && in_eop) state_d = ST_GAP;
      ST_GAP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge pcieClk_in) begin : fsm_reg
    if (reset_in) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign txValid_out = (count_q != 2'd0);
  assign txData_out  = txValid_out ? head[63:0] : 64'd0;
  assign txSOP_out   = txValid_out & head[65];
  assign txEOP_out   = txValid_out & head[64];
  assign pop         = txValid_out & txReady_in;

  // Skid buffer bookkeeping and the sticky protocol-error flag.
  always_comb begin : skid_next
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    if (accept && !pop) count_d = count_q + 2'd1;
    if (!accept && pop) count_d = count_q - 2'd1;
    if (accept) mem_d[wr_ptr_q] = {in_sop, in_eop, reqData_in[cur_idx]};
    err_d = err_q | ((state_q == ST_IDLE) && (|(reqValid_in & ~reqSOP_in)));
  end

  // Skid buffer and error registers; reset flushes any partial packet.
  always_ff @(posedge pcieClk_in) begin : skid_reg
    if (reset_in) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign grant_out       = grant;
  assign protocolErr_out = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tlp_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_tlp_tx_arbiter
// Brief   : Directed plus randomized bench for tlp_tx_arbiter against a
//           packet-level reference model (transmit queue + grant owner).
// Revision: 1.0 - initial release
// ============================================================================
module tb_tlp_tx_arbiter;

  localparam int N = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0][63:0] rdata;
  logic [N-1:0]      rsop, reop, rvalid, rready, gnt;
  logic [63:0]       txd;
  logic              txs, txe, txv, txr, perr;

  always #5 clk = ~clk;

  tlp_tx_arbiter #(.NUM_REQ(N)) dut (
    .pcieClk_in      (clk),
    .reset_in        (rst),
    .reqData_in      (rdata),
    .reqSOP_in       (rsop),
    .reqEOP_in       (reop),
    .reqValid_in     (rvalid),
    .reqReady_out    (rready),
    .txData_out      (txd),
    .txSOP_out       (txs),
    .txEOP_out       (txe),
    .txValid_out     (txv),
    .txReady_in      (txr),
    .grant_out       (gnt),
    .protocolErr_out (perr)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = free, 1 = packet owned, 2 = post-packet gap.
  int           m_mode;
  int           m_last;
  int           m_owner;
  bit           m_err;
  logic [65:0]  m_q[$];
  logic [N-1:0] m_acc;

  // Requester packet generators.
  int       g_len[N];
  int       g_pos[N];
  int       g_cnt[N];
  int       force_len;
  int       valid_pct;
  bit [N-1:0] active;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_last  = N - 1;
    m_owner = 0;
    m_err   = 1'b0;
    m_q.delete();
  endtask

  task automatic reset_gens();
    for (int i = 0; i < N; i++) begin
      g_len[i] = 0;
      g_pos[i] = 0;
    end
  endtask

  // One cycle: inputs already driven after negedge; check, update model, advance.
  task automatic step();
    logic [N-1:0] eg, er;
    logic [65:0]  head;
    int k;
    #1;
    eg = '0;
    if (!rst) begin
      if (m_mode == 0 && m_q.size() < 2) begin
        for (int off = 1; off <= N; off++) begin
          int idx;
          idx = (m_last + off) % N;
          if (rvalid[idx] && rsop[idx]) begin
            eg[idx] = 1'b1;
            break;
          end
        end
      end else if (m_mode == 1) begin
        eg[m_owner] = 1'b1;
      end
    end
    er   = (m_q.size() < 2) ? eg : '0;
    head = (m_q.size() > 0) ? m_q[0] : 66'd0;
    chk("grant",        64'(gnt),    64'(eg));
    chk("req_ready",    64'(rready), 64'(er));
    chk("tx_valid",     64'(txv),    64'(m_q.size() > 0));
    chk("tx_data",      txd,         head[63:0]);
    chk("tx_sop",       64'(txs),    64'(head[65]));
    chk("tx_eop",       64'(txe),    64'(head[64]));
    chk("protocol_err", 64'(perr),   64'(m_err));
    m_acc = rvalid & er;
    if (rst) begin
      model_reset();
    end else begin
      if (m_mode == 0 && |(rvalid & ~rsop)) m_err = 1'b1;
      if (m_q.size() > 0 && txr) void'(m_q.pop_front());
      k = -1;
      for (int i = 0; i < N; i++) if (m_acc[i]) k = i;
      if (k >= 0) m_q.push_back({rsop[k], reop[k], rdata[k]});
      if (m_mode == 2) begin
        m_mode = 0;
      end else if (k >= 0) begin
        if (m_mode == 0) begin
          m_last = k;
          if (!(rsop[k] && reop[k])) begin
            m_mode  = 1;
            m_owner = k;
          end
        end else if (reop[k]) begin
          m_mode = 2;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic gen_inputs();
    for (int i = 0; i < N; i++) begin
      if (active[i] && g_len[i] == 0) begin
        g_len[i] = (force_len != 0) ? force_len : int'($urandom_range(1, 6));
        g_pos[i] = 0;
      end
      if (g_len[i] != 0 && $urandom_range(0, 99) < valid_pct) begin
        rvalid[i] = 1'b1;
        rsop[i]   = (g_pos[i] == 0);
        reop[i]   = (g_pos[i] == g_len[i] - 1);
        rdata[i]  = {8'(i), 24'(g_cnt[i]), 32'(g_pos[i])};
      end else begin
        rvalid[i] = 1'b0;
        rsop[i]   = 1'($urandom);
        reop[i]   = 1'($urandom);
        rdata[i]  = {$urandom, $urandom};
      end
    end
  endtask

  task automatic advance();
    for (int i = 0; i < N; i++) begin
      if (m_acc[i]) begin
        g_pos[i]++;
        if (g_pos[i] == g_len[i]) begin
          g_len[i] = 0;
          g_cnt[i]++;
        end
      end
    end
  endtask

  task automatic run_gen(input int cycles, input int txpct, input bit pattern);
    for (int c = 0; c < cycles; c++) begin
      gen_inputs();
      txr = pattern ? ((c % 4 == 0) || (c % 4 == 3)) : ($urandom_range(0, 99) < txpct);
      step();
      advance();
    end
  endtask

  task automatic drain();
    active    = '0;
    valid_pct = 100;
    force_len = 0;
    run_gen(60, 100, 1'b0);
  endtask

  task automatic idle_inputs();
    rvalid = '0;
    rsop   = '0;
    reop   = '0;
    rdata  = '0;
  endtask

  initial begin
    rst = 1'b1;
    txr = 1'b1;
    idle_inputs();
    model_reset();
    reset_gens();
    for (int i = 0; i < N; i++) g_cnt[i] = 0;
    active    = '0;
    force_len = 0;
    valid_pct = 100;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();

    // Single requester, 4-beat TLP 0x1000..0x1003.
    for (int b = 0; b < 4; b++) begin
      idle_inputs();
      rvalid[0] = 1'b1;
      rsop[0]   = (b == 0);
      reop[0]   = (b == 3);
      rdata[0]  = 64'h1000 + 64'(b);
      step();
    end
    idle_inputs();
    repeat (4) step();

    // Contention: 3-beat TLPs from req0 and req1.
    reset_gens();
    active = 3'b011; force_len = 3; valid_pct = 100;
    run_gen(32, 100, 1'b0);
    drain();

    // Backpressure on 8-beat packets from req0.
    active = 3'b001; force_len = 8; valid_pct = 100;
    run_gen(40, 0, 1'b1);
    drain();

    // Back-to-back single-beat TLPs from req0 and req1.
    active = 3'b011; force_len = 1; valid_pct = 100;
    run_gen(20, 100, 1'b0);
    drain();

    // Protocol error: req1 presents a non-SOP beat while idle.
    idle_inputs();
    repeat (3) step();
    rvalid[1] = 1'b1;
    rdata[1]  = 64'hDEAD;
    step();
    idle_inputs();
    step();
    chk("err_set", 64'(perr), 64'd1);
    repeat (3) step();
    chk("err_sticky", 64'(perr), 64'd1);

    // Reset after beat 2 of a 5-beat TLP, then a fresh TLP from req1.
    for (int b = 0; b < 3; b++) begin
      idle_inputs();
      rvalid[0] = 1'b1;
      rsop[0]   = (b == 0);
      rdata[0]  = 64'h2000 + 64'(b);
      rst       = (b == 2);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();
    chk("rst_tx_valid", 64'(txv), 64'd0);
    chk("rst_err", 64'(perr), 64'd0);
    for (int b = 0; b < 3; b++) begin
      idle_inputs();
      rvalid[1] = 1'b1;
      rsop[1]   = (b == 0);
      reop[1]   = (b == 2);
      rdata[1]  = 64'h3000 + 64'(b);
      step();
    end
    idle_inputs();
    repeat (4) step();

    // Randomized traffic from all requesters with random backpressure.
    reset_gens();
    active = 3'b111; force_len = 0; valid_pct = 70;
    run_gen(2000, 60, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
